// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Control FSM for a multicycle MIPS datapath. It steps the shared PC, IR,
//   register file, ALU and block memory through fetch, decode, execute,
//   memory and writeback for R-type, lw, sw and beq instructions.
//   It handshakes with block memory through MemReady. It raises sticky flags
//   for undecodable opcodes and for memory accesses that time out.
//
//   Optional feature: define MCTRL_JUMP_EN to decode opcode 2 (j) into the
//   JUMP state. When the macro is undefined, opcode 2 is treated as illegal.
//
// Parameters
//   MEM_TIMEOUT  maximum wait cycles per memory access (0 disables timeout)
//   CNT_W        wait-counter width, 2**CNT_W > MEM_TIMEOUT
//
// Ports
//   CLK          rising-edge clock
//   Reset        asynchronous active-low reset
//   Opcode       IR[31:26], used only in DECODE and MEMADR
//   MemReady     memory completes the requested access this cycle
//   PCWrite .. RegDst, PCSource, ALUOp, ALUSrcB   datapath controls
//   State        current state encoding (debug)
//   IllegalOp    sticky flag for an undecodable opcode
//   MemError     sticky flag for a memory timeout or a corrupted state
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [3:0] State,
  output logic       IllegalOp,
  output logic       MemError
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_RWB    = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;
  localparam logic [3:0] S_HALT   = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // The last wait cycle of an access: a still-missing MemReady here abandons it.
  localparam logic [CNT_W-1:0] C_CNT_LAST =
    (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_isWait;
  logic             w_setIll;
  logic             w_setMemErr;

  // Next-state logic. A memory timeout overrides the normal transition,
  // but a MemReady on the final wait cycle still completes the access.
  always_comb begin
    w_next      = r_state;
    w_isWait    = 1'b0;
    w_setIll    = 1'b0;
    w_setMemErr = 1'b0;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH: begin
        w_isWait = 1'b1;
        if (MemReady) w_next = S_DECODE;
      end
      S_DECODE: begin
        case (Opcode)
          OP_RTYPE:     w_next = S_EXEC;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BRANCH;
`ifdef MCTRL_JUMP_EN
          OP_J:         w_next = S_JUMP;
`endif
          default: begin
            // The PC has already advanced, so the bad instruction is skipped.
            w_setIll = 1'b1;
            w_next   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: w_next = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        w_isWait = 1'b1;
        if (MemReady) w_next = S_MEMWB;
      end
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR: begin
        w_isWait = 1'b1;
        if (MemReady) w_next = S_FETCH;
      end
      S_EXEC:   w_next = S_RWB;
      S_RWB:    w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
`ifdef MCTRL_JUMP_EN
      S_JUMP:   w_next = S_FETCH;
`endif
      S_HALT:   w_next = S_HALT;
      default: begin
        w_next      = S_HALT;
        w_setMemErr = 1'b1;
      end
    endcase
    if ((MEM_TIMEOUT > 0) && w_isWait && !MemReady && (r_cnt == C_CNT_LAST)) begin
      w_next      = S_HALT;
      w_setMemErr = 1'b1;
    end
  end

  // State, wait counter and sticky flags. Any state change clears the
  // counter. This covers every entry into FETCH, MEMRD and MEMWR.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      IllegalOp <= 1'b0;
      MemError  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_cnt <= '0;
      else if (w_isWait)     r_cnt <= r_cnt + CNT_W'(1);
      if (w_setIll)    IllegalOp <= 1'b1;
      if (w_setMemErr) MemError  <= 1'b1;
    end
  end

  // Moore output decode. In FETCH, IRWrite and PCWrite follow MemReady so
  // that the IR and PC update only on the cycle the fetch completes.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcB     = 2'b00;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
`ifdef MCTRL_JUMP_EN
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
`endif
      default: ;
    endcase
  end

  assign State = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl
//   Directed, table-driven bench for mips_multicycle_ctrl. The bench drives
//   one instance with the default timeout and a second instance with
//   MEM_TIMEOUT=4. Control outputs are packed MSB-first in this order:
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
//   ALUSrcA, RegWrite, RegDst, PCSource[1:0], ALUOp[1:0], ALUSrcB[1:0].
module tb_mips_multicycle_ctrl;

  localparam logic [15:0] C_ZERO   = 16'h0000;
  localparam logic [15:0] C_FETCH0 = 16'h1001;
  localparam logic [15:0] C_FETCH1 = 16'h9201;
  localparam logic [15:0] C_DECODE = 16'h0003;
  localparam logic [15:0] C_MEMADR = 16'h0102;
  localparam logic [15:0] C_MEMRD  = 16'h3000;
  localparam logic [15:0] C_MEMWB  = 16'h0480;
  localparam logic [15:0] C_MEMWR  = 16'h2800;
  localparam logic [15:0] C_EXEC   = 16'h0108;
  localparam logic [15:0] C_RWB    = 16'h00C0;
  localparam logic [15:0] C_BRANCH = 16'h4114;
  localparam logic [15:0] C_JUMP   = 16'h8020;

  typedef struct {
    logic       mr;
    logic [5:0] op;
    logic [3:0] st;
    logic [15:0] ctrl;
    logic       ill;
    logic       merr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       rst4N = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       memReady = 1'b0;
  logic       memReady4 = 1'b0;

  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic ALUSrcA, RegWrite, RegDst, IllegalOp, MemError;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic [3:0] State;

  logic PCWrite4, PCWriteCond4, IorD4, MemRead4, MemWrite4, MemtoReg4, IRWrite4;
  logic ALUSrcA4, RegWrite4, RegDst4, IllegalOp4, MemError4;
  logic [1:0] PCSource4, ALUOp4, ALUSrcB4;
  logic [3:0] State4;

  logic [15:0] ctrl, ctrl4;
  assign ctrl  = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                  ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB};
  assign ctrl4 = {PCWrite4, PCWriteCond4, IorD4, MemRead4, MemWrite4, MemtoReg4, IRWrite4,
                  ALUSrcA4, RegWrite4, RegDst4, PCSource4, ALUOp4, ALUSrcB4};

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .CLK(clk), .Reset(rstN), .Opcode(opcode), .MemReady(memReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcB(ALUSrcB), .State(State), .IllegalOp(IllegalOp), .MemError(MemError)
  );

  mips_multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut4 (
    .CLK(clk), .Reset(rst4N), .Opcode(opcode), .MemReady(memReady4),
    .PCWrite(PCWrite4), .PCWriteCond(PCWriteCond4), .IorD(IorD4), .MemRead(MemRead4),
    .MemWrite(MemWrite4), .MemtoReg(MemtoReg4), .IRWrite(IRWrite4), .ALUSrcA(ALUSrcA4),
    .RegWrite(RegWrite4), .RegDst(RegDst4), .PCSource(PCSource4), .ALUOp(ALUOp4),
    .ALUSrcB(ALUSrcB4), .State(State4), .IllegalOp(IllegalOp4), .MemError(MemError4)
  );

  // Compares one value and counts the check.
  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs to the main instance on the falling edge.
  task automatic applyStimulus(input logic mr, input logic [5:0] op);
    @(negedge clk);
    memReady = mr;
    opcode   = op;
    #1;
  endtask

  task automatic addVec(input logic mr, input logic [5:0] op, input logic [3:0] st,
                        input logic [15:0] c, input logic ill, input logic merr);
    vec_t v;
    v.mr = mr; v.op = op; v.st = st; v.ctrl = c; v.ill = ill; v.merr = merr;
    vecs.push_back(v);
  endtask

  initial begin
    // Per-cycle program, starting from the cycle right after reset is released.
    addVec(0, 0,  0, C_ZERO,   0, 0);
    addVec(1, 0,  1, C_FETCH1, 0, 0);
    addVec(1, 0,  2, C_DECODE, 0, 0);
    addVec(1, 0,  7, C_EXEC,   0, 0);
    addVec(1, 0,  8, C_RWB,    0, 0);
    addVec(1, 35, 1, C_FETCH1, 0, 0);
    addVec(1, 35, 2, C_DECODE, 0, 0);
    addVec(1, 35, 3, C_MEMADR, 0, 0);
    addVec(0, 35, 4, C_MEMRD,  0, 0);
    addVec(0, 35, 4, C_MEMRD,  0, 0);
    addVec(0, 35, 4, C_MEMRD,  0, 0);
    addVec(1, 35, 4, C_MEMRD,  0, 0);
    addVec(0, 35, 5, C_MEMWB,  0, 0);
    addVec(1, 43, 1, C_FETCH1, 0, 0);
    addVec(1, 43, 2, C_DECODE, 0, 0);
    addVec(1, 43, 3, C_MEMADR, 0, 0);
    addVec(0, 43, 6, C_MEMWR,  0, 0);
    addVec(1, 43, 6, C_MEMWR,  0, 0);
    addVec(0, 4,  1, C_FETCH0, 0, 0);
    addVec(1, 4,  1, C_FETCH1, 0, 0);
    addVec(1, 4,  2, C_DECODE, 0, 0);
    addVec(1, 4,  9, C_BRANCH, 0, 0);
    addVec(1, 2,  1, C_FETCH1, 0, 0);
    addVec(1, 2,  2, C_DECODE, 0, 0);
`ifdef MCTRL_JUMP_EN
    addVec(1, 2,  10, C_JUMP,  0, 0);
    addVec(1, 63, 1, C_FETCH1, 0, 0);
    addVec(1, 63, 2, C_DECODE, 0, 0);
`else
    addVec(1, 63, 1, C_FETCH1, 1, 0);
    addVec(1, 63, 2, C_DECODE, 1, 0);
`endif
    addVec(1, 35, 1, C_FETCH1, 1, 0);

    // Reset state of the main instance.
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_state", {12'd0, State}, 16'd0);
    checkOutput("reset_ctrl", ctrl, C_ZERO);
    checkOutput("reset_flags", {14'd0, IllegalOp, MemError}, 16'd0);

    @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) @(negedge clk);
      memReady = vecs[i].mr;
      opcode   = vecs[i].op;
      #1;
      checkOutput($sformatf("vec%0d_state", i), {12'd0, State}, {12'd0, vecs[i].st});
      checkOutput($sformatf("vec%0d_ctrl", i), ctrl, vecs[i].ctrl);
      checkOutput($sformatf("vec%0d_flags", i), {14'd0, IllegalOp, MemError},
                  {14'd0, vecs[i].ill, vecs[i].merr});
    end

    // Asynchronous reset in the middle of a pending load.
    applyStimulus(1, 35);
    checkOutput("seqA_decode", {12'd0, State}, 16'd2);
    applyStimulus(1, 35);
    checkOutput("seqA_memadr", {12'd0, State}, 16'd3);
    applyStimulus(0, 35);
    checkOutput("seqA_memrd_ctrl", ctrl, C_MEMRD);
    #2 rstN = 1'b0;
    #1;
    checkOutput("seqA_async_ctrl", ctrl, C_ZERO);
    checkOutput("seqA_async_state", {12'd0, State}, 16'd0);
    checkOutput("seqA_async_flags", {14'd0, IllegalOp, MemError}, 16'd0);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    checkOutput("seqA_release_state", {12'd0, State}, 16'd0);

    // Default timeout of 16: fetch stalls for 16 cycles and halts.
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(0, 0);
      checkOutput($sformatf("seqB_wait%0d", k), {12'd0, State}, 16'd1);
    end
    checkOutput("seqB_noerr_yet", {15'd0, MemError}, 16'd0);
    applyStimulus(1, 0);
    checkOutput("seqB_halt_state", {12'd0, State}, 16'd15);
    checkOutput("seqB_halt_err", {15'd0, MemError}, 16'd1);
    checkOutput("seqB_halt_ctrl", ctrl, C_ZERO);
    applyStimulus(1, 4);
    checkOutput("seqB_halt_absorb", {12'd0, State}, 16'd15);

    // MemReady on the last allowed wait cycle wins over the timeout.
    @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    for (int k = 1; k <= 15; k++) applyStimulus(0, 0);
    applyStimulus(1, 0);
    checkOutput("seqB_last_fetch", ctrl, C_FETCH1);
    applyStimulus(0, 0);
    checkOutput("seqB_last_decode", {12'd0, State}, 16'd2);
    checkOutput("seqB_last_noerr", {15'd0, MemError}, 16'd0);

    // MEM_TIMEOUT=4 instance: four idle fetch cycles abandon the access.
    @(negedge clk);
    rst4N = 1'b1;
    #1;
    checkOutput("seqC_idle", {12'd0, State4}, 16'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      memReady4 = 1'b0;
      #1;
      checkOutput($sformatf("seqC_wait%0d", k), {12'd0, State4}, 16'd1);
    end
    @(negedge clk);
    #1;
    checkOutput("seqC_halt_state", {12'd0, State4}, 16'd15);
    checkOutput("seqC_halt_err", {15'd0, MemError4}, 16'd1);

    rst4N = 1'b0;
    @(negedge clk);
    rst4N = 1'b1;
    #1;
    checkOutput("seqC_reset_err", {15'd0, MemError4}, 16'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      memReady4 = (k == 4);
      #1;
      checkOutput($sformatf("seqC_race%0d", k), {12'd0, State4}, 16'd1);
    end
    checkOutput("seqC_race_ctrl", ctrl4, C_FETCH1);
    @(negedge clk);
    memReady4 = 1'b0;
    #1;
    checkOutput("seqC_race_decode", {12'd0, State4}, 16'd2);
    checkOutput("seqC_race_noerr", {15'd0, MemError4}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
